// File: rtl/wb2lb_pkg.sv
// -----------------------------------------------------------------------------
// wb2lb_pkg
// Shared types and default sizes for the Wishbone -> local-bus bridge.
//   state_t      : bridge FSM states
//   *_DEF        : default parameter values for the bridge
// -----------------------------------------------------------------------------
package wb2lb_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/wb2lb_timeout.sv
// -----------------------------------------------------------------------------
// wb2lb_timeout
// Wait counter for the bridge. Cleared while the bridge is idle, counts each
// cycle spent waiting for the local bus, flags expiry at TIMEOUT-1.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clr_i        force count to zero
//   en_i         count this cycle
//   expired_o    registered; high once the count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module wb2lb_timeout
    import wb2lb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             expired_q;

    // Expiry is computed from the next count so the flag is a plain register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else if (en_i && !expired_q) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            expired_q <= ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT - 1));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/wb2lb_bridge.sv
// -----------------------------------------------------------------------------
// wb2lb_bridge
// Wishbone classic slave to local-bus bridge. Each cyc/stb cycle becomes one
// lb write (wen held until wready) or one lb read (ren pulse, wait rvalid),
// answered with a single wb_ack_o pulse. One access outstanding at a time.
// Optional wait timeout under macro WB2LB_TIMEOUT_EN: on expiry the access is
// abandoned and wb_err_o pulses instead of wb_ack_o. Without the macro the
// bridge waits indefinitely and wb_err_o stays 0.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   wb_adr_i/dat_i/we_i/stb_i/cyc_i/sel_i   Wishbone request from the master
//   wb_dat_o/ack_o/err_o                 Wishbone response (registered)
//   lb_waddr/wdata/wstrb/wen, lb_wready  lb write channel
//   lb_raddr/ren, lb_rdata/rvalid        lb read channel
// -----------------------------------------------------------------------------
module wb2lb_bridge
    import wb2lb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic [STRB_W-1:0] wb_sel_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              wen_q,   wen_d;
    logic              ren_q,   ren_d;
    logic              ack_q,   ack_d;
    logic              err_q,   err_d;
    logic [DATA_W-1:0] dat_q,   dat_d;
    logic              abort_q, abort_d;
    logic              live_c;
    logic              to_expired;

`ifdef WB2LB_TIMEOUT_EN
    // Counter is held clear in IDLE, so it starts from zero on entry to WR/RD.
    wb2lb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == IDLE),
        .en_i      ((state_q == WR) || (state_q == RD)),
        .expired_o (to_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign to_expired     = 1'b0;
`endif

    // Master still wants the answer: cyc never dropped during this access.
    assign live_c = wb_cyc_i && !abort_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        raddr_d = raddr_q;
        wen_d   = wen_q;
        ren_d   = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        abort_d = abort_q;

        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (wb_cyc_i && wb_stb_i) begin
                    if (wb_we_i) begin
                        waddr_d = wb_adr_i;
                        wdata_d = wb_dat_i;
                        wstrb_d = wb_sel_i;
                        wen_d   = 1'b1;
                        state_d = WR;
                    end else begin
                        raddr_d = wb_adr_i;
                        ren_d   = 1'b1;
                        state_d = RD;
                    end
                end
            end
            WR: begin
                if (!wb_cyc_i) abort_d = 1'b1;
                // Handshake is checked before expiry so it wins on a tie.
                if (wen_q && lb_wready) begin
                    wen_d   = 1'b0;
                    ack_d   = live_c;
                    state_d = live_c ? ACK : IDLE;
                end else if (to_expired) begin
                    wen_d   = 1'b0;
                    err_d   = live_c;
                    state_d = live_c ? ACK : IDLE;
                end
            end
            RD: begin
                if (!wb_cyc_i) abort_d = 1'b1;
                if (lb_rvalid) begin
                    if (live_c) dat_d = lb_rdata;
                    ack_d   = live_c;
                    state_d = live_c ? ACK : IDLE;
                end else if (to_expired) begin
                    err_d   = live_c;
                    state_d = live_c ? ACK : IDLE;
                end
            end
            // Response cycle: stb is still high from the master, so it is not sampled here.
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            raddr_q <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            raddr_q <= raddr_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            abort_q <= abort_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign lb_waddr = waddr_q;
    assign lb_wdata = wdata_q;
    assign lb_wstrb = wstrb_q;
    assign lb_wen   = wen_q;
    assign lb_raddr = raddr_q;
    assign lb_ren   = ren_q;

endmodule

// File: tb/tb_wb2lb_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb2lb_bridge
// Self-checking bench for wb2lb_bridge. A table of Wishbone accesses with the
// lb response delay and expected results drives the bridge; expected responses
// are queued when a request is issued and compared when ack/err appears.
// Hand-written sequences cover cyc abort, reset mid-access and, when
// WB2LB_TIMEOUT_EN is defined, the wait timeout.
// -----------------------------------------------------------------------------
module tb_wb2lb_bridge;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int          TO    = 16;
    localparam int          BOUND = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic          wb_we_i;
    logic          wb_stb_i;
    logic          wb_cyc_i;
    logic [SW-1:0] wb_sel_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic [AW-1:0] lb_waddr;
    logic [DW-1:0] lb_wdata;
    logic [SW-1:0] lb_wstrb;
    logic          lb_wen;
    logic          lb_wready;
    logic [AW-1:0] lb_raddr;
    logic          lb_ren;
    logic [DW-1:0] lb_rdata;
    logic          lb_rvalid;

    wb2lb_bridge #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .STRB_W  (SW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_we_i   (wb_we_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_sel_i  (wb_sel_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .lb_waddr  (lb_waddr),
        .lb_wdata  (lb_wdata),
        .lb_wstrb  (lb_wstrb),
        .lb_wen    (lb_wen),
        .lb_wready (lb_wready),
        .lb_raddr  (lb_raddr),
        .lb_ren    (lb_ren),
        .lb_rdata  (lb_rdata),
        .lb_rvalid (lb_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            lat;      // lb response delay in cycles after the request appears
        logic [DW-1:0] rdata;
        logic          exp_err;
        logic [DW-1:0] exp_dat;  // wb_dat_o after the access
    } vec_t;

    typedef struct {
        logic          err;
        logic          we;
        logic [DW-1:0] rdata;
        int            cyc;      // response cycle index after the request edge
    } sb_t;

    sb_t sb_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        lb_wready = 1'b0;
        lb_rvalid = 1'b0;
    endtask

    // One complete access with an lb responder answering after v.lat cycles.
    task automatic run_access(input vec_t v);
        sb_t exp;
        int  req_cycles;
        bit  done;
        bit  unstable;
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = v.we;
        wb_adr_i = v.adr;
        wb_dat_i = v.dat;
        wb_sel_i = v.sel;
        sb_q.push_back('{err: v.exp_err, we: v.we, rdata: v.rdata,
                         cyc: v.exp_err ? TO : v.lat + 1});
        @(negedge clk);
        if (v.we) begin
            check("req_wen",   32'(lb_wen),   32'd1);
            check("req_waddr", 32'(lb_waddr), 32'(v.adr));
            check("req_wdata", lb_wdata,      v.dat);
            check("req_wstrb", 32'(lb_wstrb), 32'(v.sel));
        end else begin
            check("req_ren",   32'(lb_ren),   32'd1);
            check("req_raddr", 32'(lb_raddr), 32'(v.adr));
        end
        req_cycles = 0;
        done       = 1'b0;
        unstable   = 1'b0;
        for (int c = 0; c < BOUND && !done; c++) begin
            if (wb_ack_o || wb_err_o) begin
                done = 1'b1;
                exp  = sb_q.pop_front();
                check("resp_err",   32'(wb_err_o), 32'(exp.err));
                check("resp_ack",   32'(wb_ack_o), 32'(!exp.err));
                check("resp_cycle", 32'(c),        32'(exp.cyc));
                if (!exp.we && !exp.err) check("resp_rdata", wb_dat_o, exp.rdata);
                check("resp_wen_low", 32'(lb_wen), 32'd0);
            end else begin
                if (v.we ? lb_wen : lb_ren) req_cycles++;
                if (v.we && lb_wen &&
                    (lb_waddr !== v.adr || lb_wdata !== v.dat || lb_wstrb !== v.sel))
                    unstable = 1'b1;
                lb_wready = v.we && (c >= v.lat);
                lb_rvalid = !v.we && (c == v.lat);
                lb_rdata  = (c == v.lat) ? v.rdata : (32'hBAD0_0000 | 32'(c));
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no ack/err within %0d cycles at adr 0x%0h", BOUND, v.adr);
            void'(sb_q.pop_front());
        end
        idle_bus();
        check("req_cycles", 32'(req_cycles),
              32'(v.we ? (v.exp_err ? TO : v.lat + 1) : 1));
        if (v.we) check("wr_stable", 32'(unstable), 32'd0);
        check("dat_after", wb_dat_o, v.exp_dat);
        @(negedge clk);
        check("resp_pulse", 32'({wb_ack_o, wb_err_o}), 32'd0);
    endtask

    // Master drops cyc right after the request; lb still answers after lat cycles.
    task automatic run_abort(input logic we, input logic [AW-1:0] adr, input int lat);
        int req_cycles;
        int resp;
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = 32'h5555_AAAA;
        wb_sel_i = 4'hF;
        @(negedge clk);
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        req_cycles = 0;
        resp       = 0;
        for (int c = 0; c < lat + 8; c++) begin
            if (we ? lb_wen : lb_ren) req_cycles++;
            if (wb_ack_o || wb_err_o) resp++;
            lb_wready = we && (c >= lat);
            lb_rvalid = !we && (c == lat);
            lb_rdata  = 32'h7777_0000;
            @(negedge clk);
        end
        idle_bus();
        check("abort_resp",       32'(resp),       32'd0);
        check("abort_req_cycles", 32'(req_cycles), 32'(we ? lat + 1 : 1));
        check("abort_wen_low",    32'(lb_wen),     32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vec_t v;
        reset    = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        lb_rdata = '0;
        idle_bus();

        vecs[0] = '{1'b1, 16'h0010, 32'hCAFE_BABE, 4'hF, 0, 32'h0,         1'b0, 32'h0};
        vecs[1] = '{1'b0, 16'h0020, 32'h0,         4'hF, 3, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 16'h0030, 32'hA5A5_0F0F, 4'h3, 5, 32'h0,         1'b0, 32'h1234_5678};
        vecs[3] = '{1'b0, 16'hFFFC, 32'h0,         4'hF, 2, 32'h0,         1'b0, 32'h0};
        vecs[4] = '{1'b1, 16'h0040, 32'h1111_2222, 4'h0, 1, 32'h0,         1'b0, 32'h0};
        vecs[5] = '{1'b0, 16'h0044, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 16'hFFFE, 32'hFFFF_FFFF, 4'hF, 2, 32'h0,         1'b0, 32'hDEAD_BEEF};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ack",   32'(wb_ack_o), 32'd0);
        check("rst_err",   32'(wb_err_o), 32'd0);
        check("rst_dat",   wb_dat_o,      32'd0);
        check("rst_wen",   32'(lb_wen),   32'd0);
        check("rst_ren",   32'(lb_ren),   32'd0);
        check("rst_waddr", 32'(lb_waddr), 32'd0);
        check("rst_wdata", lb_wdata,      32'd0);
        check("rst_wstrb", 32'(lb_wstrb), 32'd0);
        check("rst_raddr", 32'(lb_raddr), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_access(vecs[i]);

        // cyc dropped mid-read and mid-write, then a normal write.
        run_abort(1'b0, 16'h0060, 3);
        run_abort(1'b1, 16'h0064, 3);
        v = '{1'b1, 16'h0004, 32'h0000_0001, 4'hF, 0, 32'h0, 1'b0, 32'hDEAD_BEEF};
        run_access(v);

        // Reset while a write is waiting for wready.
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 16'h0050;
        wb_dat_i = 32'h1357_2468;
        wb_sel_i = 4'hF;
        repeat (3) @(negedge clk);
        check("mid_wen_pre", 32'(lb_wen), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_wen",   32'(lb_wen),   32'd0);
        check("mid_rst_ack",   32'(wb_ack_o), 32'd0);
        check("mid_rst_dat",   wb_dat_o,      32'd0);
        check("mid_rst_waddr", 32'(lb_waddr), 32'd0);
        @(negedge clk);
        idle_bus();
        reset = 1'b0;
        v = '{1'b0, 16'h0008, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};
        run_access(v);

`ifdef WB2LB_TIMEOUT_EN
        // Write and read that never complete, then a handshake on the expiry edge.
        v = '{1'b1, 16'h0070, 32'h2468_ACE0, 4'hF, 1000, 32'h0, 1'b1, 32'h0BAD_F00D};
        run_access(v);
        v = '{1'b0, 16'h0074, 32'h0, 4'hF, 1000, 32'h0, 1'b1, 32'h0BAD_F00D};
        run_access(v);
        v = '{1'b1, 16'h0078, 32'h0F0F_F0F0, 4'hF, TO - 1, 32'h0, 1'b0, 32'h0BAD_F00D};
        run_access(v);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
